// File: rtl/rvsteel_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rvsteel_uart_tx_fifo
//  Description : Byte FIFO in front of the UART. A drain FSM polls the UART
//                TX-ready bit and writes the head byte once the UART is free.
//                Define RVSTEEL_UART_TX_FIFO_IRQ_EN to add the tx_empty_irq output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rvsteel_uart_tx_fifo #(
   parameter int         FIFO_DEPTH   = 16,
   parameter logic [4:0] UART_TX_ADDR = 5'h00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  rw_address,
   output logic [31:0] read_data,
   input  logic        read_request,
   output logic        read_response,
   input  logic [7:0]  write_data,
   input  logic        write_request,
   output logic        write_response,
   output logic [4:0]  uart_rw_address,
   input  logic [31:0] uart_read_data,
   output logic        uart_read_request,
   input  logic        uart_read_response,
   output logic [7:0]  uart_write_data,
   output logic        uart_write_request,
   input  logic        uart_write_response
`ifdef RVSTEEL_UART_TX_FIFO_IRQ_EN
   ,
   output logic        tx_empty_irq
`endif
);

   localparam int                c_PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [c_PTR_W:0]   c_LEVEL_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [c_PTR_W:0]   c_LEVEL_ONE  = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
   localparam logic [4:0]         c_ADDR_DATA  = 5'h00;
   localparam logic [4:0]         c_ADDR_LEVEL = 5'h04;
   localparam logic [4:0]         c_ADDR_CTRL  = 5'h08;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POLL      = 3'd1,
      ST_WAIT_POLL = 3'd2,
      ST_SEND      = 3'd3,
      ST_WAIT_SEND = 3'd4
   } state_t;

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_level;
   logic [c_PTR_W:0]   w_level_next;
   logic               r_overflow;
   state_t             r_state;

   logic        r_read_response;
   logic        r_write_response;
   logic [31:0] r_read_data;
   logic [31:0] w_read_value;
   logic        r_uart_read_request;
   logic        r_uart_write_request;
   logic [7:0]  r_uart_write_data;
   logic [4:0]  r_uart_rw_address;

   logic w_empty, w_full;
   logic w_push_req, w_ctrl_wr, w_flush, w_clr_ovf;
   logic w_pop, w_push, w_drop;
   logic w_unused;

   assign w_empty    = (r_level == '0);
   assign w_full     = (r_level == c_LEVEL_FULL);
   assign w_push_req = write_request && (rw_address == c_ADDR_DATA);
   assign w_ctrl_wr  = write_request && (rw_address == c_ADDR_CTRL);
   assign w_flush    = w_ctrl_wr && write_data[0];
   assign w_clr_ovf  = w_ctrl_wr && write_data[1];

   // SEND is only entered with a non-empty FIFO; a flush in that cycle cancels the pop.
   assign w_pop  = (r_state == ST_SEND) && !w_flush;
   assign w_push = w_push_req && !w_flush && (!w_full || w_pop);
   assign w_drop = w_push_req && !w_flush && w_full && !w_pop;

   assign w_unused = ^uart_read_data[31:1];

   always_comb begin
      w_level_next = r_level;
      if (w_flush) begin
         w_level_next = '0;
      end else if (w_push && !w_pop) begin
         w_level_next = r_level + c_LEVEL_ONE;
      end else if (w_pop && !w_push) begin
         w_level_next = r_level - c_LEVEL_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= write_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_level <= w_level_next;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      w_read_value = '0;
      case (rw_address)
         c_ADDR_DATA:  w_read_value = {29'b0, r_overflow, w_full, w_empty};
         c_ADDR_LEVEL: w_read_value = 32'(r_level);
         default:      w_read_value = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_read_response  <= 1'b0;
         r_write_response <= 1'b0;
         r_read_data      <= '0;
      end else begin
         r_read_response  <= read_request;
         r_write_response <= write_request;
         r_read_data      <= read_request ? w_read_value : '0;
      end
   end

   // Strobes are raised on entry to POLL/SEND so they are high only in those states.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state              <= ST_IDLE;
         r_uart_read_request  <= 1'b0;
         r_uart_write_request <= 1'b0;
         r_uart_write_data    <= '0;
         r_uart_rw_address    <= '0;
      end else begin
         r_uart_read_request  <= 1'b0;
         r_uart_write_request <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_state             <= ST_POLL;
                  r_uart_read_request <= 1'b1;
                  r_uart_rw_address   <= UART_TX_ADDR;
               end
            end
            ST_POLL: begin
               r_state <= ST_WAIT_POLL;
            end
            ST_WAIT_POLL: begin
               if (uart_read_response) begin
                  if (w_empty || w_flush) begin
                     r_state <= ST_IDLE;
                  end else if (uart_read_data[0]) begin
                     r_state              <= ST_SEND;
                     r_uart_write_request <= 1'b1;
                     r_uart_write_data    <= r_mem[r_rd_ptr];
                     r_uart_rw_address    <= UART_TX_ADDR;
                  end else begin
                     r_state             <= ST_POLL;
                     r_uart_read_request <= 1'b1;
                     r_uart_rw_address   <= UART_TX_ADDR;
                  end
               end
            end
            ST_SEND: begin
               r_state <= ST_WAIT_SEND;
            end
            ST_WAIT_SEND: begin
               if (uart_write_response) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RVSTEEL_UART_TX_FIFO_IRQ_EN
   logic r_tx_empty_irq;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_tx_empty_irq <= 1'b0;
      end else if ((r_level != '0) && (w_level_next == '0)) begin
         r_tx_empty_irq <= 1'b1;
      end else if ((w_ctrl_wr && write_data[2]) || w_push) begin
         r_tx_empty_irq <= 1'b0;
      end
   end

   assign tx_empty_irq = r_tx_empty_irq;
`endif

   assign read_data          = r_read_data;
   assign read_response      = r_read_response;
   assign write_response     = r_write_response;
   assign uart_rw_address    = r_uart_rw_address;
   assign uart_read_request  = r_uart_read_request;
   assign uart_write_request = r_uart_write_request;
   assign uart_write_data    = r_uart_write_data;

endmodule
`default_nettype wire

// File: doc/rvsteel_uart_tx_fifo.md
Name: rvsteel_uart_tx_fifo

Overview:
Transmit buffer placed directly upstream of the UART on the IO bus. Software pushes bytes into a FIFO through a bus-slave port. An internal master FSM drains the FIFO into the UART through the UART's native IO interface: it polls the UART TX-ready status at address 0x00 and then writes the head byte to 0x00. This removes per-byte busy-polling from the CPU.

Parameters:
FIFO_DEPTH, 16, number of byte entries; power of two, minimum 2.
UART_TX_ADDR, 5'h00, UART address used for both the status poll and the TX write.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
rw_address  input  5  slave register address
read_data  output  32  slave read data, registered
read_request  input  1  slave read strobe
read_response  output  1  slave read acknowledge
write_data  input  8  slave write data
write_request  input  1  slave write strobe
write_response  output  1  slave write acknowledge
uart_rw_address  output  5  master address to UART
uart_read_data  input  32  UART read data
uart_read_request  output  1  master read strobe to UART
uart_read_response  input  1  UART read acknowledge
uart_write_data  output  8  byte to UART
uart_write_request  output  1  master write strobe to UART
uart_write_response  input  1  UART write acknowledge

Behaviour:
- Reset is asynchronous and active-high. Reset clears all state immediately: both pointers, level, the overflow flag and the FSM (to IDLE). All outputs are 0 during and after reset.
- Slave responses: read_response and write_response equal the previous cycle's read_request and write_request (1-cycle latency). read_data is registered and valid in the same cycle as read_response; it is 0 when there is no read.
- Slave register map:
  - 0x00 write: push write_data.
  - 0x00 read: {29'b0, overflow, full, empty}.
  - 0x04 read: {zero-pad, level}.
  - 0x08 write: if write_data[0]=1, flush; if write_data[1]=1, clear overflow.
  - Any other address reads 0 and ignores writes.
- Push while full: the byte is dropped, overflow is set (sticky), and write_response is still returned.
- Level range is 0..FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle: both take effect and level is unchanged. When full, a same-cycle pop makes room and the push is accepted with no overflow.
- Flush resets both pointers and level to 0. A flush in the same cycle as a push wins (the byte is discarded). An in-flight UART transaction still completes but does not pop.
- Drain FSM states:
  - IDLE: if not empty, go to POLL.
  - POLL: uart_read_request=1 for exactly 1 cycle with uart_rw_address=UART_TX_ADDR, then go to WAIT_POLL.
  - WAIT_POLL: hold until uart_read_response=1. Then, if uart_read_data[0]=1 and the FIFO is not empty, go to SEND. If uart_read_data[0]=0, go to POLL. If the FIFO became empty (flush), go to IDLE.
  - SEND: uart_write_request=1 for exactly 1 cycle, uart_write_data=head byte, uart_rw_address=UART_TX_ADDR. Pop in this cycle, then go to WAIT_SEND.
  - WAIT_SEND: hold until uart_write_response=1, then go to IDLE.
- Outside POLL and SEND, uart_read_request and uart_write_request are 0, and uart_write_data holds its last value.
- The UART becomes busy in the cycle after SEND, so the next poll observes busy. A byte is never written to the UART unless status bit 0=1 was read in that same poll loop.
- Minimum spacing between successive UART writes is 5 cycles plus the UART frame time.

Optional Feature:
RVSTEEL_UART_TX_FIFO_IRQ_EN.
- Defined: adds output port tx_empty_irq (1 bit). It goes high the cycle after a pop or flush takes level from nonzero to 0. It stays high until a slave write to 0x08 with write_data[2]=1, or until the next accepted push. Reset value is 0.
- Undefined: the port is absent, and write_data[2] at 0x08 is ignored.

Test Plan:
- Reset mid-SEND (assert reset with uart_write_request=1) -> the request drops in the same cycle. After release, read 0x00 = 0x1, read 0x04 = 0, no UART traffic.
- Push 0x41, 0x42, 0x43 with a UART model ready -> UART writes 0x41, 0x42, 0x43 in order, each preceded by a poll returning bit0=1. Level read after completion = 0.
- UART model returns bit0=0 for 10 polls, then 1 -> exactly 11 uart_read_requests and 1 uart_write_request. The byte is unchanged.
- With FIFO_DEPTH=16, block the UART and push 17 bytes -> 0x00 reads 0x6 (overflow, full), 0x04 reads 16. Then write 0x08 = 0x2 -> 0x00 reads 0x2.
- Full FIFO, with a push coinciding with the SEND pop -> level stays 16, overflow stays 0. The pushed byte is later transmitted as the 17th byte overall.
- With IRQ_EN defined: push 1 byte and let it drain -> tx_empty_irq=1 the cycle after the pop. Write 0x08 = 0x4 -> tx_empty_irq=0 the next cycle.
